lc3_decode: RTL and testbench

- Decode stage of the 5-stage LC-3 pipeline, between fetch and execute.
- When enabled, it captures the fetched instruction word and its next-PC.
- It also generates registered control bundles for execute (e_control), writeback (w_control) and memory (mem_control).
- All outputs are registered, with one cycle of latency from a qualified clock edge.

---
 rtl/lc3_decode.sv | 217 +++++++++++++++++++++
 tb/tb_lc3_decode.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lc3_decode.sv
// -----------------------------------------------------------------------------
// lc3_decode
//
// Decode stage of the 5-stage LC-3 pipeline, sitting between fetch and execute.
// On an enabled clock edge the stage captures the fetched instruction word and
// its next-PC. It also registers the control bundles consumed downstream by
// execute, writeback and memory. With the enable low the stage stalls, so every
// output holds. All outputs come straight from flops, with one cycle of latency.
//
// Ports:
//   clk            in   1   system clock, rising-edge active
//   rst            in   1   synchronous active-high reset; wins over enable
//   enable_decode  in   1   1 = capture/decode this edge, 0 = hold (stall)
//   npc_in         in  16   next-PC (PC+1) from fetch
//   instr_mem_dout in  16   instruction word from instruction memory
//   psr            in   3   NZP status; not used by this stage
//   ir             out 16   registered instruction word
//   npc_out        out 16   registered next-PC
//   e_control      out  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   w_control      out  2   00 ALU result, 01 memory data, 10 computed PC (LEA)
//   mem_control    out  1   1 = indirect access (LDI/STI)
// -----------------------------------------------------------------------------
module lc3_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_decode,
    input  logic [15:0] npc_in,
    input  logic [15:0] instr_mem_dout,
    input  logic [2:0]  psr,
    output logic [15:0] ir,
    output logic [15:0] npc_out,
    output logic [5:0]  e_control,
    output logic [1:0]  w_control,
    output logic        mem_control
);

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    // Field encodings for the execute bundle.
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;

    localparam logic [1:0] PC1_NONE = 2'b00;
    localparam logic [1:0] PC1_OFF9 = 2'b01;
    localparam logic [1:0] PC1_OFF6 = 2'b10;
    localparam logic [1:0] PC1_ZERO = 2'b11;

    localparam logic       PC2_NPC  = 1'b1;
    localparam logic       PC2_VSR1 = 1'b0;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;

    // psr is part of the stage interface but carries no information needed
    // here; the reduction keeps the input connected without affecting logic.
    logic psr_unused;
    assign psr_unused = ^psr;

    opcode_e opcode;
    logic    imm_flag;

    assign opcode   = opcode_e'(instr_mem_dout[15:12]);
    assign imm_flag = instr_mem_dout[5];

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction word.
    // ------------------------------------------------------------------
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
    logic [1:0] dec_w_control;
    logic       dec_mem_control;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case statement leaves it unassigned, which
        // would otherwise infer a latch.
        alu_control     = ALU_ADD;
        pcselect1       = PC1_NONE;
        pcselect2       = PC2_VSR1;
        op2select       = 1'b0;
        dec_w_control   = WB_ALU;
        dec_mem_control = 1'b0;

        unique case (opcode)
            OP_ADD: begin
                alu_control = ALU_ADD;
                op2select   = ~imm_flag;  // register form selects VSR2
            end
            OP_AND: begin
                alu_control = ALU_AND;
                op2select   = ~imm_flag;
            end
            OP_NOT: begin
                alu_control = ALU_NOT;
            end
            // PC-relative forms: npc + sext(offset9).
            OP_BR, OP_ST: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = PC2_NPC;
            end
            OP_LD: begin
                pcselect1     = PC1_OFF9;
                pcselect2     = PC2_NPC;
                dec_w_control = WB_MEM;
            end
            OP_LDI: begin
                pcselect1       = PC1_OFF9;
                pcselect2       = PC2_NPC;
                dec_w_control   = WB_MEM;
                dec_mem_control = 1'b1;
            end
            OP_STI: begin
                pcselect1       = PC1_OFF9;
                pcselect2       = PC2_NPC;
                dec_mem_control = 1'b1;
            end
            OP_LEA: begin
                pcselect1     = PC1_OFF9;
                pcselect2     = PC2_NPC;
                dec_w_control = WB_PC;
            end
            // Base-relative forms: VSR1 + sext(offset6).
            OP_LDR: begin
                pcselect1     = PC1_OFF6;
                pcselect2     = PC2_VSR1;
                dec_w_control = WB_MEM;
            end
            OP_STR: begin
                pcselect1 = PC1_OFF6;
                pcselect2 = PC2_VSR1;
            end
            // JMP target is VSR1 + 0.
            OP_JMP: begin
                pcselect1 = PC1_ZERO;
                pcselect2 = PC2_VSR1;
            end
            // JSR, RTI, TRAP and the reserved opcode produce an all-zero
            // control bundle; the word and next-PC still pass through.
            OP_JSR, OP_RTI, OP_RES, OP_TRAP: begin
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: capture on enable, otherwise hold (stall).
    // ------------------------------------------------------------------
    logic [15:0] ir_d,          ir_q;
    logic [15:0] npc_d,         npc_q;
    logic [5:0]  e_control_d,   e_control_q;
    logic [1:0]  w_control_d,   w_control_q;
    logic        mem_control_d, mem_control_q;

    always_comb begin
        ir_d          = ir_q;
        npc_d         = npc_q;
        e_control_d   = e_control_q;
        w_control_d   = w_control_q;
        mem_control_d = mem_control_q;

        if (enable_decode) begin
            ir_d          = instr_mem_dout;
            npc_d         = npc_in;
            e_control_d   = {alu_control, pcselect1, pcselect2, op2select};
            w_control_d   = dec_w_control;
            mem_control_d = dec_mem_control;
        end
    end

    // Reset is sampled here so it overrides the enable on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs, independent of statement order.
        if (rst) begin
            ir_q          <= '0;
            npc_q         <= '0;
            e_control_q   <= '0;
            w_control_q   <= '0;
            mem_control_q <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            npc_q         <= npc_d;
            e_control_q   <= e_control_d;
            w_control_q   <= w_control_d;
            mem_control_q <= mem_control_d;
        end
    end

    assign ir          = ir_q;
    assign npc_out     = npc_q;
    assign e_control   = e_control_q;
    assign w_control   = w_control_q;
    assign mem_control = mem_control_q;

endmodule

// File: tb/tb_lc3_decode.sv
// -----------------------------------------------------------------------------
// tb_lc3_decode
//
// Directed testbench for lc3_decode. Inputs change on the falling edge and
// outputs are sampled 1ns after the rising edge. Expected values are
// hand-computed from the decode table.
// -----------------------------------------------------------------------------
module tb_lc3_decode;

    logic        clk;
    logic        rst;
    logic        enable_decode;
    logic [15:0] npc_in;
    logic [15:0] instr_mem_dout;
    logic [2:0]  psr;
    logic [15:0] ir;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic        mem_control;

    int checks   = 0;
    int failures = 0;

    lc3_decode dut (
        .clk            (clk),
        .rst            (rst),
        .enable_decode  (enable_decode),
        .npc_in         (npc_in),
        .instr_mem_dout (instr_mem_dout),
        .psr            (psr),
        .ir             (ir),
        .npc_out        (npc_out),
        .e_control      (e_control),
        .w_control      (w_control),
        .mem_control    (mem_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic en, input logic [15:0] instr,
                        input logic [15:0] npc);
        @(negedge clk);
        rst            = r;
        enable_decode  = en;
        instr_mem_dout = instr;
        npc_in         = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp_ir,
                             input logic [15:0] exp_npc, input logic [5:0] exp_e,
                             input logic [1:0] exp_w, input logic exp_m);
        check({tag, ".ir"},  ir,                   exp_ir);
        check({tag, ".npc"}, npc_out,              exp_npc);
        check({tag, ".e"},   {10'd0, e_control},   {10'd0, exp_e});
        check({tag, ".w"},   {14'd0, w_control},   {14'd0, exp_w});
        check({tag, ".m"},   {15'd0, mem_control}, {15'd0, exp_m});
    endtask

    task automatic run_vec(input string tag, input logic [15:0] instr,
                           input logic [15:0] npc, input logic [5:0] exp_e,
                           input logic [1:0] exp_w, input logic exp_m);
        step(1'b0, 1'b1, instr, npc);
        check_all(tag, instr, npc, exp_e, exp_w, exp_m);
    endtask

    initial begin
        rst            = 1'b1;
        enable_decode  = 1'b1;
        instr_mem_dout = 16'h1042;
        npc_in         = 16'h3001;
        psr            = 3'b000;

        // Reset wins over enable for two edges.
        step(1'b1, 1'b1, 16'h1042, 16'h3001);
        check_all("rst0", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0);
        step(1'b1, 1'b1, 16'h1042, 16'h3001);
        check_all("rst1", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0);

        // Release reset: first enabled edge captures.
        run_vec("add_reg",  16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0);
        run_vec("add_imm",  16'h1261, 16'h3002, 6'b000000, 2'b00, 1'b0);
        run_vec("and_reg",  16'h5042, 16'h3003, 6'b010001, 2'b00, 1'b0);
        run_vec("and_imm",  16'h5061, 16'h3004, 6'b010000, 2'b00, 1'b0);
        run_vec("not",      16'h907F, 16'h3005, 6'b100000, 2'b00, 1'b0);
        run_vec("br",       16'h0E03, 16'h3006, 6'b000110, 2'b00, 1'b0);
        run_vec("jmp",      16'hC1C0, 16'h3007, 6'b001100, 2'b00, 1'b0);
        run_vec("ld",       16'h2005, 16'h3008, 6'b000110, 2'b01, 1'b0);
        run_vec("ldr",      16'h6243, 16'h3009, 6'b001000, 2'b01, 1'b0);
        run_vec("ldi",      16'hA005, 16'h300A, 6'b000110, 2'b01, 1'b1);
        run_vec("lea",      16'hE005, 16'h300B, 6'b000110, 2'b10, 1'b0);
        run_vec("st",       16'h3005, 16'h300C, 6'b000110, 2'b00, 1'b0);
        run_vec("str",      16'h7243, 16'h300D, 6'b001000, 2'b00, 1'b0);
        run_vec("sti",      16'hB005, 16'h300E, 6'b000110, 2'b00, 1'b1);
        run_vec("trap",     16'hF025, 16'h300F, 6'b000000, 2'b00, 1'b0);
        run_vec("jsr",      16'h4803, 16'h3010, 6'b000000, 2'b00, 1'b0);
        run_vec("rti",      16'h8000, 16'h3011, 6'b000000, 2'b00, 1'b0);
        run_vec("reserved", 16'hD123, 16'h3012, 6'b000000, 2'b00, 1'b0);

        // Stall: outputs hold for three disabled edges despite new inputs.
        run_vec("stall_ld", 16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'hA005, 16'h3002);
            check_all($sformatf("stall%0d", i), 16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0);
        end

        // psr has no influence on any output.
        run_vec("psr_base", 16'h5042, 16'h4000, 6'b010001, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            psr = 3'b001 << i;
            @(posedge clk);
            #1;
            check_all($sformatf("psr%0d", i), 16'h5042, 16'h4000, 6'b010001, 2'b00, 1'b0);
        end
        psr = 3'b000;

        // Mid-stream reset clears an LDI that would otherwise be captured.
        run_vec("pre_rst", 16'hB005, 16'h5000, 6'b000110, 2'b00, 1'b1);
        step(1'b1, 1'b1, 16'hA005, 16'h5001);
        check_all("mid_rst", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0);

        // Recovery: stays zero while disabled, captures on first enabled edge.
        step(1'b0, 1'b0, 16'hA005, 16'h5002);
        check_all("recov_hold", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0);
        run_vec("recov_cap", 16'hA005, 16'h5003, 6'b000110, 2'b01, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
